ins_analyser: RTL and testbench

//  Decodes a 32-bit MIPS-style R/I/J instruction word into one-hot class flags and writeback hints.

---
 rtl/ins_analyser.sv | 107 ++++++++++
 tb/tb_ins_analyser.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/ins_analyser.sv
// ins_analyser: combinational MIPS-style R/I/J instruction class decode with
// writeback hints, plus clocked first-illegal-instruction capture.
// Optional statistics counters are enabled by defining INS_ANALYSER_STATS_EN.
module ins_analyser #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      IR,
  input  logic             ir_valid,
  output logic             isLoad,
  output logic             isStore,
  output logic             isALUR,
  output logic             isALUImm,
  output logic             isBranch,
  output logic             isJump,
  output logic             isNop,
  output logic             isIllegal,
  output logic             wr_en,
  output logic             wr_rt,
  output logic             illegal_seen,
  output logic [31:0]      illegal_ir,
  output logic [CNT_W-1:0] ins_count,
  output logic [CNT_W-1:0] illegal_count
);

  localparam int unsigned OP_W    = 6;
  localparam int unsigned FUNCT_W = 6;

  logic [OP_W-1:0]    op;
  logic [FUNCT_W-1:0] funct;

  assign op    = IR[31:26];
  assign funct = IR[5:0];

  // Class decode: only op (and funct when op==0) select the class; IR==0 is the canonical NOP.
  always_comb begin
    isLoad   = 1'b0;
    isStore  = 1'b0;
    isALUR   = 1'b0;
    isALUImm = 1'b0;
    isBranch = 1'b0;
    isJump   = 1'b0;
    isNop    = (IR == 32'h0);
    case (op)
      6'h00: begin
        if (!isNop) begin
          case (funct)
            6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
            6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
            6'h2A, 6'h2B: isALUR = 1'b1;
            6'h08:        isJump = 1'b1;
            default:      ;
          endcase
        end
      end
      6'h02, 6'h03:                      isJump   = 1'b1;
      6'h04, 6'h05:                      isBranch = 1'b1;
      6'h08, 6'h09, 6'h0A, 6'h0B,
      6'h0C, 6'h0D, 6'h0E, 6'h0F:        isALUImm = 1'b1;
      6'h20, 6'h21, 6'h23, 6'h24, 6'h25: isLoad   = 1'b1;
      6'h28, 6'h29, 6'h2B:               isStore  = 1'b1;
      default:                           ;
    endcase
    isIllegal = ~(isLoad | isStore | isALUR | isALUImm | isBranch | isJump | isNop);
  end

  // Writeback hints follow directly from the class flags.
  always_comb begin
    wr_en = isALUR | isALUImm | isLoad;
    wr_rt = isALUImm | isLoad | isStore;
  end

  // Sticky capture of the first illegal valid instruction since reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_seen <= 1'b0;
      illegal_ir   <= 32'h0;
    end else if (ir_valid && isIllegal && !illegal_seen) begin
      illegal_seen <= 1'b1;
      illegal_ir   <= IR;
    end
  end

`ifdef INS_ANALYSER_STATS_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Saturating counters of valid and illegal valid instructions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ins_count     <= '0;
      illegal_count <= '0;
    end else if (ir_valid) begin
      if (ins_count != CNT_MAX) begin
        ins_count <= ins_count + CNT_W'(1);
      end
      if (isIllegal && (illegal_count != CNT_MAX)) begin
        illegal_count <= illegal_count + CNT_W'(1);
      end
    end
  end
`else
  assign ins_count     = '0;
  assign illegal_count = '0;
`endif

endmodule

// File: tb/tb_ins_analyser.sv
// tb_ins_analyser: directed table of instruction words with hand-computed class
// flags, capture/stats sequences, and an op x funct one-hot sweep.
module tb_ins_analyser;

  localparam int unsigned CNT_W = 16;

  localparam logic [7:0] F_LOAD = 8'h80;
  localparam logic [7:0] F_STOR = 8'h40;
  localparam logic [7:0] F_ALUR = 8'h20;
  localparam logic [7:0] F_AIMM = 8'h10;
  localparam logic [7:0] F_BRAN = 8'h08;
  localparam logic [7:0] F_JUMP = 8'h04;
  localparam logic [7:0] F_NOP  = 8'h02;
  localparam logic [7:0] F_ILL  = 8'h01;

  typedef struct {
    logic [31:0] ir;
    logic [7:0]  flags;
    logic        wr_en;
    logic        wr_rt;
  } vec_t;

  logic             clk;
  logic             rst_n;
  logic [31:0]      IR;
  logic             ir_valid;
  logic             isLoad, isStore, isALUR, isALUImm, isBranch, isJump, isNop, isIllegal;
  logic             wr_en, wr_rt;
  logic             illegal_seen;
  logic [31:0]      illegal_ir;
  logic [CNT_W-1:0] ins_count;
  logic [CNT_W-1:0] illegal_count;

  int checks;
  int passed;

  ins_analyser #(.CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .IR           (IR),
    .ir_valid     (ir_valid),
    .isLoad       (isLoad),
    .isStore      (isStore),
    .isALUR       (isALUR),
    .isALUImm     (isALUImm),
    .isBranch     (isBranch),
    .isJump       (isJump),
    .isNop        (isNop),
    .isIllegal    (isIllegal),
    .wr_en        (wr_en),
    .wr_rt        (wr_rt),
    .illegal_seen (illegal_seen),
    .illegal_ir   (illegal_ir),
    .ins_count    (ins_count),
    .illegal_count(illegal_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] flags_now();
    return {isLoad, isStore, isALUR, isALUImm, isBranch, isJump, isNop, isIllegal};
  endfunction

  // Reference classification written from the opcode/funct tables.
  function automatic logic [7:0] model(input logic [31:0] ir);
    logic [5:0] o;
    logic [5:0] f;
    o = ir[31:26];
    f = ir[5:0];
    if (ir == 32'h0) return F_NOP;
    if (o == 6'h00) begin
      if (f == 6'h08) return F_JUMP;
      if (f == 6'h00 || f == 6'h02 || f == 6'h03 || f == 6'h04 || f == 6'h06 || f == 6'h07 ||
          (f >= 6'h20 && f <= 6'h27) || f == 6'h2A || f == 6'h2B) return F_ALUR;
      return F_ILL;
    end
    if (o == 6'h02 || o == 6'h03) return F_JUMP;
    if (o == 6'h04 || o == 6'h05) return F_BRAN;
    if (o >= 6'h08 && o <= 6'h0F) return F_AIMM;
    if (o == 6'h20 || o == 6'h21 || o == 6'h23 || o == 6'h24 || o == 6'h25) return F_LOAD;
    if (o == 6'h28 || o == 6'h29 || o == 6'h2B) return F_STOR;
    return F_ILL;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[20];

  initial begin
    logic [7:0]  m;
    logic [31:0] w;
    logic [31:0] seq_ir[8];
    logic        seq_v[8];

    checks   = 0;
    passed   = 0;
    rst_n    = 1'b0;
    ir_valid = 1'b0;
    IR       = 32'h0;

    vecs[0]  = '{32'h8C430004, F_LOAD, 1'b1, 1'b1};
    vecs[1]  = '{32'hAC430004, F_STOR, 1'b0, 1'b1};
    vecs[2]  = '{32'h00221820, F_ALUR, 1'b1, 1'b0};
    vecs[3]  = '{32'h20420005, F_AIMM, 1'b1, 1'b1};
    vecs[4]  = '{32'h00000000, F_NOP,  1'b0, 1'b0};
    vecs[5]  = '{32'h10220003, F_BRAN, 1'b0, 1'b0};
    vecs[6]  = '{32'h08000010, F_JUMP, 1'b0, 1'b0};
    vecs[7]  = '{32'h03E00008, F_JUMP, 1'b0, 1'b0};
    vecs[8]  = '{32'h00000009, F_ILL,  1'b0, 1'b0};
    vecs[9]  = '{32'h0000000C, F_ILL,  1'b0, 1'b0};
    vecs[10] = '{32'hFC000000, F_ILL,  1'b0, 1'b0};
    vecs[11] = '{32'h00000040, F_ALUR, 1'b1, 1'b0};
    vecs[12] = '{32'h3C01FFFF, F_AIMM, 1'b1, 1'b1};
    vecs[13] = '{32'h84000000, F_LOAD, 1'b1, 1'b1};
    vecs[14] = '{32'hA0000000, F_STOR, 1'b0, 1'b1};
    vecs[15] = '{32'h0000002B, F_ALUR, 1'b1, 1'b0};
    vecs[16] = '{32'h00000028, F_ILL,  1'b0, 1'b0};
    vecs[17] = '{32'h04000000, F_ILL,  1'b0, 1'b0};
    vecs[18] = '{32'h88000000, F_ILL,  1'b0, 1'b0};
    vecs[19] = '{32'h14A5FFFF, F_BRAN, 1'b0, 1'b0};

    // Reset state.
    #2;
    check("rst_seen", 32'(illegal_seen), 32'h0);
    check("rst_ir", illegal_ir, 32'h0);
    check("rst_ins_cnt", 32'(ins_count), 32'h0);
    check("rst_ill_cnt", 32'(illegal_count), 32'h0);
    tick();
    tick();
    rst_n = 1'b1;

    // Directed table; ir_valid low so no state moves.
    for (int i = 0; i < 20; i++) begin
      IR = vecs[i].ir;
      #1;
      check($sformatf("flags[%0d]", i), 32'(flags_now()), 32'(vecs[i].flags));
      check($sformatf("wr_en[%0d]", i), 32'(wr_en), 32'(vecs[i].wr_en));
      check($sformatf("wr_rt[%0d]", i), 32'(wr_rt), 32'(vecs[i].wr_rt));
      tick();
    end
    check("no_capture_invalid", 32'(illegal_seen), 32'h0);

    // First-illegal capture, no overwrite, async clear.
    IR = 32'hFC000000;
    ir_valid = 1'b1;
    tick();
    check("cap_seen", 32'(illegal_seen), 32'h1);
    check("cap_ir", illegal_ir, 32'hFC000000);
    IR = 32'h00000009;
    tick();
    check("keep_ir", illegal_ir, 32'hFC000000);
    ir_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_seen", 32'(illegal_seen), 32'h0);
    check("async_ir", illegal_ir, 32'h0);
    check("async_cnt", 32'(ins_count), 32'h0);
    tick();
    rst_n = 1'b1;

    // Mixed valid/invalid sequence: 5 valid, 2 of them illegal.
    seq_ir = '{32'hFFFFFFFF, 32'h8C430004, 32'h00000009, 32'h00000000,
               32'h00221820, 32'h0000000C, 32'h20420005, 32'h03E00008};
    seq_v  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 8; i++) begin
      IR = seq_ir[i];
      ir_valid = seq_v[i];
      tick();
    end
    ir_valid = 1'b0;
    check("seq_seen", 32'(illegal_seen), 32'h1);
    check("seq_ir", illegal_ir, 32'h00000009);
`ifdef INS_ANALYSER_STATS_EN
    check("seq_ins_cnt", 32'(ins_count), 32'd5);
    check("seq_ill_cnt", 32'(illegal_count), 32'd2);
    tick();
    check("hold_ins_cnt", 32'(ins_count), 32'd5);

    // Saturation: more than 2^CNT_W valid illegal samples.
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    IR = 32'hFC000000;
    ir_valid = 1'b1;
    for (int i = 0; i < 65538; i++) tick();
    ir_valid = 1'b0;
    check("sat_ins_cnt", 32'(ins_count), 32'h0000FFFF);
    check("sat_ill_cnt", 32'(illegal_count), 32'h0000FFFF);
`else
    check("seq_ins_cnt", 32'(ins_count), 32'h0);
    check("seq_ill_cnt", 32'(illegal_count), 32'h0);
`endif

    // op x funct sweep with random other fields.
    for (int o = 0; o < 64; o++) begin
      for (int f = 0; f < 64; f++) begin
        w = $urandom();
        w[31:26] = 6'(o);
        w[5:0]   = 6'(f);
        IR = w;
        #1;
        m = model(w);
        check($sformatf("sweep_onehot op=%0h f=%0h", o, f), 32'($countones(flags_now())), 32'd1);
        check($sformatf("sweep_class op=%0h f=%0h", o, f), 32'(flags_now()), 32'(m));
        check($sformatf("sweep_wr op=%0h f=%0h", o, f), 32'({wr_en, wr_rt}),
              32'({(m & (F_ALUR | F_AIMM | F_LOAD)) != 8'h0,
                   (m & (F_AIMM | F_LOAD | F_STOR)) != 8'h0}));
      end
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
